// File: rtl/jt12_lfo_pkg.sv
// Shared constants for the jt12 low-frequency oscillator.
// Holds the per-rate divider limits and the AM sensitivity shifts.
package jt12_lfo_pkg;

    localparam int LFO_CNT_W = 7;
    localparam int LFO_DIV_W = 7;

    // Frames per LFO step, indexed by lfo_freq
    localparam logic [LFO_DIV_W-1:0] LFO_LIMIT [8] = '{
        7'd108, 7'd77, 7'd71, 7'd67,
        7'd62,  7'd44, 7'd8,  7'd5
    };

    typedef enum logic [1:0] {
        AMS_OFF  = 2'd0,
        AMS_LOW  = 2'd1,
        AMS_MID  = 2'd2,
        AMS_FULL = 2'd3
    } ams_e;

    localparam int AMS_SHIFT_LOW = 3;
    localparam int AMS_SHIFT_MID = 1;

endpackage

// File: rtl/jt12_lfo_am.sv
// AM attenuation: triangle of the LFO step scaled by slot sensitivity.
// One register stage between ams and am_offset.
module jt12_lfo_am
    import jt12_lfo_pkg::*;
#(
    parameter int CNT_W = LFO_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic [CNT_W-1:0] lfo_mod,
    input  logic [1:0]       ams,
    output logic [CNT_W-1:0] am_offset
);

    logic [CNT_W-2:0] tri_val;
    logic [CNT_W-1:0] base;
    logic [CNT_W-1:0] am_d;
    logic [CNT_W-1:0] am_q;

    // Falling half first, rising half once the top bit is set
    assign tri_val = lfo_mod[CNT_W-1] ? lfo_mod[CNT_W-2:0]
                                      : ~lfo_mod[CNT_W-2:0];
    assign base    = {tri_val, 1'b0};

    always_comb begin
        am_d = am_q;
        if (clk_en) begin
            unique case (ams_e'(ams))
                AMS_OFF:  am_d = '0;
                AMS_LOW:  am_d = base >> AMS_SHIFT_LOW;
                AMS_MID:  am_d = base >> AMS_SHIFT_MID;
                AMS_FULL: am_d = base;
                default:  am_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            am_q <= '0;
        end else begin
            am_q <= am_d;
        end
    end

    assign am_offset = am_q;

endmodule

// File: rtl/jt12_lfo.sv
// YM2612 LFO: per-frame divider and 7-bit step counter.
// The step counter feeds PM directly and AM via jt12_lfo_am.
module jt12_lfo
    import jt12_lfo_pkg::*;
#(
    parameter int CNT_W = LFO_CNT_W,
    parameter int DIV_W = LFO_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             zero,
    input  logic             lfo_en,
    input  logic [2:0]       lfo_freq,
    input  logic [1:0]       ams,
    output logic [CNT_W-1:0] lfo_mod,
    output logic [CNT_W-1:0] am_offset
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic [DIV_W-1:0] limit;
    logic [CNT_W-1:0] mod_q;
    logic [CNT_W-1:0] mod_d;

    assign limit = DIV_W'(LFO_LIMIT[lfo_freq]);

    // >= rather than == so a lowered rate cannot strand div above limit
    always_comb begin
        div_d = div_q;
        mod_d = mod_q;
        if (clk_en && zero) begin
            if (!lfo_en) begin
                div_d = '0;
                mod_d = '0;
            end else if (div_q >= limit - DIV_W'(1)) begin
                div_d = '0;
                mod_d = mod_q + CNT_W'(1);
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            mod_q <= '0;
        end else begin
            div_q <= div_d;
            mod_q <= mod_d;
        end
    end

    assign lfo_mod = mod_q;

    jt12_lfo_am #(
        .CNT_W (CNT_W)
    ) u_am (
        .clk       (clk),
        .rst       (rst),
        .clk_en    (clk_en),
        .lfo_mod   (mod_q),
        .ams       (ams),
        .am_offset (am_offset)
    );

endmodule

// File: tb/tb_jt12_lfo.sv
// Scoreboard bench for jt12_lfo with an integer reference model.
// Stimulus pushes expectations; a monitor pops one per clock.
module tb_jt12_lfo;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_en;
    logic       zero;
    logic       lfo_en;
    logic [2:0] lfo_freq;
    logic [1:0] ams;
    logic [6:0] lfo_mod;
    logic [6:0] am_offset;

    always #5 clk = ~clk;

    jt12_lfo dut (
        .clk       (clk),
        .rst       (rst),
        .clk_en    (clk_en),
        .zero      (zero),
        .lfo_en    (lfo_en),
        .lfo_freq  (lfo_freq),
        .ams       (ams),
        .lfo_mod   (lfo_mod),
        .am_offset (am_offset)
    );

    typedef struct {
        int mod;
        int am;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    int m_div = 0;
    int m_mod = 0;
    int m_am  = 0;
    int lim_tab[8] = '{108, 77, 71, 67, 62, 44, 8, 5};

    function automatic int am_ref(int mod, int a);
        int t;
        int base;
        t    = (mod >= 64) ? (mod - 64) : (63 - mod);
        base = 2 * t;
        case (a)
            0:       return 0;
            1:       return base / 8;
            2:       return base / 2;
            default: return base;
        endcase
    endfunction

    task automatic step(input bit r, input bit ce, input bit z, input int a);
        rst    = r;
        clk_en = ce;
        zero   = z;
        ams    = 2'(a);
        if (r) begin
            m_div = 0;
            m_mod = 0;
            m_am  = 0;
        end else if (ce) begin
            m_am = am_ref(m_mod, a);
            if (z) begin
                if (!lfo_en) begin
                    m_div = 0;
                    m_mod = 0;
                end else if (m_div >= lim_tab[lfo_freq] - 1) begin
                    m_div = 0;
                    m_mod = (m_mod + 1) % 128;
                end else begin
                    m_div = m_div + 1;
                end
            end
        end
        q.push_back('{m_mod, m_am});
        @(negedge clk);
    endtask

    // One frame: a zero pulse then three slots with random clk_en
    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1, 1'b1, int'($urandom_range(0, 3)));
            for (int s = 0; s < 3; s++) begin
                step(1'b0, 1'($urandom_range(0, 1)), 1'b0,
                     int'($urandom_range(0, 3)));
            end
        end
    endtask

    task automatic chk(input string name, input logic [6:0] act, input int exp_v);
        vectors++;
        if (act !== 7'(exp_v)) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                if (lfo_mod !== 7'(e.mod) || am_offset !== 7'(e.am)) begin
                    miscompares++;
                    $display("FAIL scoreboard t=%0t: lfo_mod %0d/%0d am %0d/%0d",
                             $time, lfo_mod, e.mod, am_offset, e.am);
                end
            end
        end
    end

    initial begin : stim
        int hold;
        rst      = 1'b1;
        clk_en   = 1'b1;
        zero     = 1'b0;
        lfo_en   = 1'b0;
        lfo_freq = 3'd0;
        ams      = 2'd0;
        @(negedge clk);

        repeat (3) step(1'b1, 1'b1, 1'b0, 3);
        chk("reset_mod", lfo_mod, 0);
        chk("reset_am", am_offset, 0);

        frames(200);
        chk("idle_mod", lfo_mod, 0);

        // AM shaping at lfo_mod = 0
        step(1'b0, 1'b1, 1'b0, 3);
        chk("am3_mod0", am_offset, 126);
        step(1'b0, 1'b1, 1'b0, 2);
        chk("am2_mod0", am_offset, 63);
        step(1'b0, 1'b1, 1'b0, 1);
        chk("am1_mod0", am_offset, 15);
        step(1'b0, 1'b1, 1'b0, 0);
        chk("am0_mod0", am_offset, 0);

        // Fastest rate
        lfo_en   = 1'b1;
        lfo_freq = 3'd7;
        frames(4);
        chk("fast_4", lfo_mod, 0);
        frames(1);
        chk("fast_5", lfo_mod, 1);
        frames(635);
        chk("fast_wrap", lfo_mod, 0);
        frames(320);
        chk("fast_64", lfo_mod, 64);
        step(1'b0, 1'b1, 1'b0, 3);
        chk("am3_mod64", am_offset, 0);

        // zero pulses while clk_en is low are ignored
        hold = int'(lfo_mod);
        repeat (12) step(1'b0, 1'b0, 1'b1, int'($urandom_range(0, 3)));
        chk("ce_hold", lfo_mod, hold);

        // Slowest rate from a clean start
        lfo_en = 1'b0;
        frames(1);
        lfo_en   = 1'b1;
        lfo_freq = 3'd0;
        frames(107);
        chk("slow_107", lfo_mod, 0);
        frames(1);
        chk("slow_108", lfo_mod, 1);

        // Rate change mid-count
        lfo_en = 1'b0;
        frames(1);
        lfo_en   = 1'b1;
        lfo_freq = 3'd0;
        frames(50);
        lfo_freq = 3'd6;
        frames(1);
        chk("rate_chg", lfo_mod, 1);
        frames(7);
        chk("rate_7", lfo_mod, 1);
        frames(1);
        chk("rate_8", lfo_mod, 2);

        // Disable mid-run
        lfo_en = 1'b0;
        frames(1);
        lfo_en   = 1'b1;
        lfo_freq = 3'd7;
        frames(185);
        chk("dis_37", lfo_mod, 37);
        lfo_en = 1'b0;
        repeat (5) step(1'b0, 1'b1, 1'b0, int'($urandom_range(0, 3)));
        chk("dis_hold", lfo_mod, 37);
        frames(1);
        chk("dis_clear", lfo_mod, 0);
        frames(20);
        chk("dis_stay", lfo_mod, 0);

        // Random rates, enables and resets
        for (int k = 0; k < 30; k++) begin
            lfo_freq = 3'($urandom_range(0, 7));
            lfo_en   = ($urandom_range(0, 7) != 0);
            frames(int'($urandom_range(1, 20)));
            if ($urandom_range(0, 15) == 0)
                step(1'b1, 1'($urandom_range(0, 1)), 1'b1, 3);
        end

        step(1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d entries left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
